tqvp_tacos_fxalu: RTL and testbench
===================================

TQVP_TACOS_FXALU -- requirements
Module: tqvp_tacos_fxalu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal values 16, 24, 32.
REQ-002 SHALL have parameter FBITS, default 16, fractional bits; unsigned Q(WIDTH-FBITS).FBITS format; FBITS < WIDTH; WIDTH+FBITS even.
REQ-003 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-005 SHALL have port ui_in, input, 8 bits, unused.
REQ-006 SHALL have port uo_out, output, 8 bits: [1]=busy, [2]=done, all other bits 0.
REQ-007 SHALL have port address, input, 6 bits, register select.
REQ-008 SHALL have port data_in, input, 32 bits, write data.
REQ-009 SHALL have port data_write_n, input, 2 bits: 11 none, 00 byte, 01 half, 10 word.
REQ-010 SHALL have port data_read_n, input, 2 bits, same encoding; unused.
REQ-011 SHALL have port data_out, output, 32 bits, read data, zero-extended from WIDTH.
REQ-012 SHALL have port data_ready, output, 1 bit, tied 1.
REQ-013 SHALL have port user_interrupt, output, 1 bit, equal to done AND irq_en.

Function
REQ-014 Address map SHALL be: 0x0 CTRL, 0x1 A, 0x2 B, 0x3 C, 0x4 CLR (write-only); all other addresses read 0.
REQ-015 CTRL SHALL be: [2:0] op (R/W), [3] start (write-1 pulse, reads 0), [4] irq_en (R/W), [8] busy, [9] done, [10] ovf, [11] err (read-only).
REQ-016 Writes SHALL honour size: byte updates [7:0], half [15:0], word all bits; bits at or above WIDTH are ignored on write.
REQ-017 Opcodes SHALL be: 0 C=sqrt(A); 1 C=rem(A); 2 C=A*A; 3 C=C+A*B; 4 C=sqrt(C); 5 C=A*B; 6 C=sqrt(A*A+B*B); 7 its remainder.
REQ-018 Multiply SHALL be shift-add, one bit per cycle, WIDTH cycles; result = (full product)>>FBITS.
REQ-019 Sqrt SHALL be restoring, one result bit per cycle, (WIDTH+FBITS)/2 cycles, on x<<FBITS; rem = (x<<FBITS) - root^2.
REQ-020 FSM states SHALL be IDLE, MUL1, MUL2, SQRT, DONE; the MUL2 state is used only by opcodes 6/7 (B*B accumulate).
REQ-021 A start write in IDLE or DONE at cycle T SHALL clear done/ovf/err and set busy from T+1; C is written and done set at T+1+L.
REQ-022 L SHALL be WIDTH (ops 2,3,5), (WIDTH+FBITS)/2 (ops 0,1,4), and 2*WIDTH+(WIDTH+FBITS)/2 (ops 6,7).
REQ-023 Any product, accumulate or intermediate sum exceeding WIDTH bits SHALL saturate to all ones and set ovf.
REQ-024 A start write while busy SHALL be ignored; writes to A, B, C or op while busy SHALL be ignored; irq_en stays writable.
REQ-025 Writing bit0=1 to CLR SHALL clear done; a CLR and a completion in the same cycle SHALL leave done set.
REQ-026 Operand values SHALL be latched at start; C read while busy returns the previous value.

Reset
REQ-027 rst SHALL zero A, B, C, op, irq_en, busy, done, ovf and err, and force state IDLE, uo_out=0 and user_interrupt=0 on the next edge.
REQ-028 rst asserted mid-operation SHALL abort it with no write to C beyond the reset zeroing.

Configuration
REQ-029 Macro TACOS_HYPOT_EN defined SHALL enable opcodes 6/7 and state MUL2.
REQ-030 Without TACOS_HYPOT_EN, a start with op 6/7 SHALL set err and done in one cycle and leave C unchanged; MUL2 logic is absent.

Structure
REQ-031 Package tqvp_tacos_pkg SHALL hold opcode constants, register address constants, CTRL bit indices and the FSM state typedef.
REQ-032 Sub-module tacos_sqrt_iter (parametrised WIDTH/FBITS; start/load, busy, valid, root, rem) SHALL implement the sqrt; the multiplier stays inline.

Verification (WIDTH=32, FBITS=16)
REQ-033 A=0x00040000, op0 start -> C=0x00020000, done after 24 cycles, busy high throughout.
REQ-034 A=0x00030000, op2 -> C=0x00090000 after 32 cycles; A=0x01000000, op2 -> C=0xFFFFFFFF, ovf=1.
REQ-035 C=0x00010000, A=0x00020000, B=0x00008000, op3 -> C=0x00020000; a second start mid-run is ignored.
REQ-036 With macro: A=0x00030000, B=0x00040000, op6 -> C=0x00050000 after 88 cycles; op7 -> C=0; without macro: op6 -> err=1, done=1, C unchanged.
REQ-037 irq_en=1 -> user_interrupt rises with done; CLR bit0 write drops it; rst at cycle 10 of op0 -> all registers 0, state IDLE, no late completion.

Source files
------------

// File: rtl/tqvp_tacos_pkg.sv
// tqvp_tacos_pkg: opcodes, register map, CTRL bit indices and FSM states for the fixed-point ALU
package tqvp_tacos_pkg;
    localparam logic [2:0] OP_SQRT   = 3'd0;
    localparam logic [2:0] OP_REM    = 3'd1;
    localparam logic [2:0] OP_SQR    = 3'd2;
    localparam logic [2:0] OP_MAC    = 3'd3;
    localparam logic [2:0] OP_SQRTC  = 3'd4;
    localparam logic [2:0] OP_MUL    = 3'd5;
    localparam logic [2:0] OP_HYP    = 3'd6;
    localparam logic [2:0] OP_HYPREM = 3'd7;
    localparam logic [5:0] ADDR_CTRL = 6'h0;
    localparam logic [5:0] ADDR_A    = 6'h1;
    localparam logic [5:0] ADDR_B    = 6'h2;
    localparam logic [5:0] ADDR_C    = 6'h3;
    localparam logic [5:0] ADDR_CLR  = 6'h4;
    localparam int CTRL_START = 3;
    localparam int CTRL_IRQ   = 4;
    localparam int CTRL_BUSY  = 8;
    localparam int CTRL_DONE  = 9;
    localparam int CTRL_OVF   = 10;
    localparam int CTRL_ERR   = 11;
    typedef enum logic [2:0] {IDLE, MUL1, MUL2, SQRT, DONE} state_t;
    // Merge write data into an old register value honouring byte/half/word size
    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] din, input logic [1:0] wn);
        return wn == 2'b00 ? {old[31:8], din[7:0]} : wn == 2'b01 ? {old[31:16], din[15:0]} : din;
    endfunction
endpackage

// File: rtl/tacos_sqrt_iter.sv
// tacos_sqrt_iter: restoring square root of x<<FBITS, one root bit per cycle; valid marks the final step, root/rem are that step's results
module tacos_sqrt_iter #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH-1:0] rem
);
    localparam int XW = WIDTH + FBITS;
    localparam int N  = XW / 2;
    localparam int RW = N + 2;
    localparam int CW = $clog2(N);
    logic [XW-1:0] d;
    logic [N-1:0]  q, q_nxt;
    logic [RW-1:0] r, r_nxt;
    logic [RW+1:0] rs, trial;
    logic [CW-1:0] cnt;
    logic          fits;
    // One restoring step: bring down two radicand bits and try to subtract 4q+1
    always_comb begin
        rs    = {r, d[XW-1:XW-2]};
        trial = {2'b00, q, 2'b01};
        fits  = rs >= trial;
        r_nxt = RW'(fits ? rs - trial : rs);
        q_nxt = {q[N-2:0], fits};
        valid = busy && cnt == CW'(N - 1);
        root  = WIDTH'(q_nxt);
        rem   = WIDTH'(r_nxt[N:0]);
    end
    // Iteration state; load restarts from a fresh radicand
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            q    <= '0;
            r    <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= '0;
            d    <= {x, {FBITS{1'b0}}};
            q    <= '0;
            r    <= '0;
        end else if (busy) begin
            busy <= !valid;
            cnt  <= cnt + 1'b1;
            d    <= d << 2;
            q    <= q_nxt;
            r    <= r_nxt;
        end
    end
endmodule

// File: rtl/tqvp_tacos_fxalu.sv
// tqvp_tacos_fxalu: unsigned fixed-point multiply/MAC/sqrt peripheral; define TACOS_HYPOT_EN for hypot opcodes 6/7
module tqvp_tacos_fxalu #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    import tqvp_tacos_pkg::*;
    localparam int MW = $clog2(WIDTH);
`ifdef TACOS_HYPOT_EN
    localparam state_t HYP_ST = MUL1;
    logic [WIDTH-1:0] acc, hyp;
    logic [WIDTH:0]   hsum;
`else
    localparam state_t HYP_ST = DONE;
`endif
    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a, b, c, mcand, msat, wv, sq_x, sq_root, sq_rem;
    logic [2*WIDTH-1:0] p, p_nxt;
    logic [WIDTH:0]    psum, mac;
    logic [MW-1:0]     mcnt;
    logic [31:0]       wm, ctrl_rd;
    logic [2:0]        op, op_new;
    logic              irq_en, done, ovf, err;
    logic              busy, wr, start_ok, mul_last, mov, sq_load, sq_busy, sq_valid;
    logic              unused_ok;
    assign unused_ok = &{1'b0, ui_in, data_read_n, sq_busy, wm};
    tacos_sqrt_iter #(.WIDTH(WIDTH), .FBITS(FBITS)) u_sqrt (
        .clk(clk), .rst(rst), .load(sq_load), .x(sq_x),
        .busy(sq_busy), .valid(sq_valid), .root(sq_root), .rem(sq_rem)
    );
    // Bus decode, shift-add multiplier step, saturation and sqrt launch
    always_comb begin
        busy     = state inside {MUL1, MUL2, SQRT};
        wr       = data_write_n != 2'b11;
        op_new   = data_in[2:0];
        start_ok = wr && address == ADDR_CTRL && data_in[CTRL_START] && !busy;
        wm       = wmerge(address == ADDR_A ? 32'(a) : address == ADDR_B ? 32'(b) : 32'(c), data_in, data_write_n);
        wv       = wm[WIDTH-1:0];
        psum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        p_nxt    = p[0] ? {psum, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
        mul_last = mcnt == MW'(WIDTH - 1);
        mov      = |p_nxt[2*WIDTH-1:WIDTH+FBITS];
        msat     = mov ? '1 : p_nxt[WIDTH+FBITS-1:FBITS];
        mac      = {1'b0, c} + {1'b0, msat};
`ifdef TACOS_HYPOT_EN
        hsum     = {1'b0, acc} + {1'b0, msat};
        hyp      = hsum[WIDTH] ? '1 : hsum[WIDTH-1:0];
        sq_load  = (start_ok && op_new inside {OP_SQRT, OP_REM, OP_SQRTC}) || (state == MUL2 && mul_last);
        sq_x     = state == MUL2 ? hyp : op_new == OP_SQRTC ? c : a;
`else
        sq_load  = start_ok && op_new inside {OP_SQRT, OP_REM, OP_SQRTC};
        sq_x     = op_new == OP_SQRTC ? c : a;
`endif
        ctrl_rd  = '0;
        ctrl_rd[2:0]      = op;
        ctrl_rd[CTRL_IRQ]  = irq_en;
        ctrl_rd[CTRL_BUSY] = busy;
        ctrl_rd[CTRL_DONE] = done;
        ctrl_rd[CTRL_OVF]  = ovf;
        ctrl_rd[CTRL_ERR]  = err;
        data_out = address == ADDR_CTRL ? ctrl_rd : address == ADDR_A ? 32'(a) : address == ADDR_B ? 32'(b) :
                   address == ADDR_C ? 32'(c) : '0;
        uo_out         = {5'b0, done, busy, 1'b0};
        data_ready     = 1'b1;
        user_interrupt = done & irq_en;
    end
    // Next-state logic; unsupported hypot opcodes go straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = op_new inside {OP_SQR, OP_MAC, OP_MUL} ? MUL1 :
                                                  op_new inside {OP_SQRT, OP_REM, OP_SQRTC} ? SQRT : HYP_ST;
`ifdef TACOS_HYPOT_EN
            MUL1: if (mul_last) state_nxt = op inside {OP_HYP, OP_HYPREM} ? MUL2 : DONE;
            MUL2: if (mul_last) state_nxt = SQRT;
`else
            MUL1: if (mul_last) state_nxt = DONE;
`endif
            SQRT: if (sq_valid) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end
    // State register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    // Register file, operation launch and result write-back; completion wins over a same-cycle CLR
    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            c      <= '0;
            op     <= '0;
            irq_en <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            mcand  <= '0;
            p      <= '0;
            mcnt   <= '0;
`ifdef TACOS_HYPOT_EN
            acc    <= '0;
`endif
        end else begin
            if (wr && !busy && address == ADDR_A) a <= wv;
            if (wr && !busy && address == ADDR_B) b <= wv;
            if (wr && !busy && address == ADDR_C) c <= wv;
            if (wr && address == ADDR_CTRL) begin
                irq_en <= data_in[CTRL_IRQ];
                if (!busy) op <= op_new;
            end
            if (wr && address == ADDR_CLR && data_in[0]) done <= 1'b0;
            if (start_ok) begin
                done  <= 1'b0;
                ovf   <= 1'b0;
                err   <= 1'b0;
                mcand <= op_new inside {OP_MAC, OP_MUL} ? b : a;
                p     <= {{WIDTH{1'b0}}, a};
                mcnt  <= '0;
`ifndef TACOS_HYPOT_EN
                if (op_new inside {OP_HYP, OP_HYPREM}) begin
                    err  <= 1'b1;
                    done <= 1'b1;
                end
`endif
            end
            if (state == MUL1 || state == MUL2) begin
                p    <= p_nxt;
                mcnt <= mcnt + 1'b1;
            end
            if (state == MUL1 && mul_last) begin
`ifdef TACOS_HYPOT_EN
                if (op inside {OP_HYP, OP_HYPREM}) begin
                    acc   <= msat;
                    ovf   <= mov;
                    mcand <= b;
                    p     <= {{WIDTH{1'b0}}, b};
                    mcnt  <= '0;
                end else
`endif
                begin
                    c    <= op == OP_MAC ? (mac[WIDTH] ? '1 : mac[WIDTH-1:0]) : msat;
                    ovf  <= mov | (op == OP_MAC && mac[WIDTH]);
                    done <= 1'b1;
                end
            end
`ifdef TACOS_HYPOT_EN
            if (state == MUL2 && mul_last) ovf <= ovf | mov | hsum[WIDTH];
`endif
            if (state == SQRT && sq_valid) begin
                c    <= op inside {OP_REM, OP_HYPREM} ? sq_rem : sq_root;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tqvp_tacos_fxalu.sv
// tb_tqvp_tacos_fxalu: table-driven scoreboard bench for the fixed-point ALU plus hand-written corner sequences
module tb_tqvp_tacos_fxalu;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  ui_in = '0, uo_out;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0, data_out;
    logic [1:0]  data_write_n = 2'b11, data_read_n = 2'b11;
    logic        data_ready, user_interrupt;
    int cyc = 0, total = 0, bad = 0;

    typedef struct {logic [2:0] op; logic [31:0] a, b, c, exp; logic ovf; int lat;} vec_t;
    typedef struct {logic [31:0] c; logic ovf; int lat;} sb_t;
    vec_t vt[$];
    sb_t  sb[$];

    tqvp_tacos_fxalu dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] ad, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        address = ad;
        data_in = d;
        data_write_n = sz;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] ad, output logic [31:0] d);
        @(negedge clk);
        address = ad;
        #1 d = data_out;
    endtask

    task automatic wait_done(input int t0, input int lim);
        while (!uo_out[2] && cyc - t0 < lim) @(negedge clk);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [31:0] d;
        sb_t e;
        int t0, lat;
        logic busy_ok;
        wr(6'h1, v.a, 2'b10);
        wr(6'h2, v.b, 2'b10);
        wr(6'h3, v.c, 2'b10);
        sb.push_back('{v.exp, v.ovf, v.lat});
        wr(6'h0, 32'h8 | 32'(v.op), 2'b00);
        t0 = cyc;
        busy_ok = 1'b1;
        while (!uo_out[2] && cyc - t0 < 200) begin
            busy_ok &= uo_out[1];
            @(negedge clk);
        end
        lat = cyc - t0;
        busy_ok &= !uo_out[1];
        e = sb.pop_front();
        rd(6'h3, d);
        chk($sformatf("v%0d c", i), d, e.c);
        rd(6'h0, d);
        chk($sformatf("v%0d ovf", i), 32'(d[10]), 32'(e.ovf));
        chk($sformatf("v%0d err", i), 32'(d[11]), 32'(0));
        chk($sformatf("v%0d latency", i), 32'(lat), 32'(e.lat));
        chk($sformatf("v%0d busy", i), 32'(busy_ok), 32'(1));
    endtask

    initial begin
        logic [31:0] d;
        sb_t e;
        int t0;
        vt.push_back('{3'd0, 32'h00040000, 32'h0, 32'h0, 32'h00020000, 1'b0, 24});
        vt.push_back('{3'd0, 32'h00020000, 32'h0, 32'h0, 32'h00016A09, 1'b0, 24});
        vt.push_back('{3'd1, 32'h00020000, 32'h0, 32'h0, 32'h00028BAF, 1'b0, 24});
        vt.push_back('{3'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00FFFFFF, 1'b0, 24});
        vt.push_back('{3'd1, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h01FEFFFF, 1'b0, 24});
        vt.push_back('{3'd0, 32'h0, 32'h0, 32'h7, 32'h0, 1'b0, 24});
        vt.push_back('{3'd4, 32'h0, 32'h0, 32'h00090000, 32'h00030000, 1'b0, 24});
        vt.push_back('{3'd2, 32'h00030000, 32'h0, 32'h0, 32'h00090000, 1'b0, 32});
        vt.push_back('{3'd2, 32'h01000000, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 32});
        vt.push_back('{3'd3, 32'h00020000, 32'h00008000, 32'h00010000, 32'h00020000, 1'b0, 32});
        vt.push_back('{3'd3, 32'h00020000, 32'h00010000, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1, 32});
        vt.push_back('{3'd5, 32'h00018000, 32'h00028000, 32'h0, 32'h0003C000, 1'b0, 32});
        vt.push_back('{3'd5, 32'h00000001, 32'h00000001, 32'h5555, 32'h0, 1'b0, 32});
        vt.push_back('{3'd5, 32'h00FF0000, 32'h01000000, 32'h0, 32'hFF000000, 1'b0, 32});
        vt.push_back('{3'd5, 32'h01000000, 32'h01000000, 32'h0, 32'hFFFFFFFF, 1'b1, 32});
`ifdef TACOS_HYPOT_EN
        vt.push_back('{3'd6, 32'h00030000, 32'h00040000, 32'h0, 32'h00050000, 1'b0, 88});
        vt.push_back('{3'd7, 32'h00030000, 32'h00040000, 32'h0, 32'h0, 1'b0, 88});
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd(6'h0, d); chk("reset ctrl", d, 32'h0);
        rd(6'h1, d); chk("reset a", d, 32'h0);
        rd(6'h3, d); chk("reset c", d, 32'h0);
        chk("reset uo_out", 32'(uo_out), 32'h0);
        chk("reset irq", 32'(user_interrupt), 32'h0);
        chk("data_ready", 32'(data_ready), 32'h1);

        wr(6'h1, 32'h12345678, 2'b10);
        wr(6'h1, 32'hFFFFFFAB, 2'b00);
        rd(6'h1, d); chk("byte write", d, 32'h123456AB);
        wr(6'h1, 32'hFFFF9876, 2'b01);
        rd(6'h1, d); chk("half write", d, 32'h12349876);
        wr(6'h5, 32'hFFFFFFFF, 2'b10);
        rd(6'h5, d); chk("unmapped read", d, 32'h0);

        foreach (vt[i]) run_vec(i, vt[i]);

        wr(6'h3, 32'h00010000, 2'b10);
        wr(6'h1, 32'h00020000, 2'b10);
        wr(6'h2, 32'h00008000, 2'b10);
        sb.push_back('{32'h00020000, 1'b0, 32});
        wr(6'h0, 32'h0B, 2'b00);
        t0 = cyc;
        rd(6'h3, d); chk("busy c read", d, 32'h00010000);
        wr(6'h0, 32'h08, 2'b00);
        wr(6'h1, 32'h0, 2'b10);
        wait_done(t0, 200);
        chk("midrun latency", 32'(cyc - t0), 32'(32));
        e = sb.pop_front();
        rd(6'h3, d); chk("midrun c", d, e.c);
        rd(6'h1, d); chk("midrun a kept", d, 32'h00020000);
        rd(6'h0, d); chk("midrun op kept", 32'(d[2:0]), 32'h3);

`ifndef TACOS_HYPOT_EN
        wr(6'h3, 32'h1234, 2'b10);
        wr(6'h1, 32'h00030000, 2'b10);
        wr(6'h2, 32'h00040000, 2'b10);
        wr(6'h0, 32'h0E, 2'b00);
        chk("noh done", 32'(uo_out[2:1]), 32'h2);
        rd(6'h0, d); chk("noh err", 32'(d[11]), 32'h1);
        rd(6'h3, d); chk("noh c kept", d, 32'h1234);
`endif

        wr(6'h1, 32'h00030000, 2'b10);
        wr(6'h0, 32'h0A, 2'b00);
        t0 = cyc;
        while (cyc < t0 + 31) @(negedge clk);
        address = 6'h4;
        data_in = 32'h1;
        data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
        chk("clr vs done", 32'(uo_out[2]), 32'h1);
        rd(6'h3, d); chk("clr op2 c", d, 32'h00090000);
        wr(6'h4, 32'h1, 2'b10);
        chk("clr done", 32'(uo_out[2]), 32'h0);

        wr(6'h0, 32'h10, 2'b00);
        chk("irq idle", 32'(user_interrupt), 32'h0);
        wr(6'h1, 32'h00040000, 2'b10);
        wr(6'h0, 32'h18, 2'b00);
        t0 = cyc;
        wait_done(t0, 200);
        chk("irq rise", 32'(user_interrupt), 32'h1);
        wr(6'h4, 32'h1, 2'b00);
        chk("irq drop", 32'(user_interrupt), 32'h0);

        wr(6'h2, 32'h00050000, 2'b10);
        wr(6'h0, 32'h08, 2'b00);
        t0 = cyc;
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(6'h0, d); chk("rst ctrl", d, 32'h0);
        rd(6'h1, d); chk("rst a", d, 32'h0);
        rd(6'h2, d); chk("rst b", d, 32'h0);
        rd(6'h3, d); chk("rst c", d, 32'h0);
        chk("rst uo_out", 32'(uo_out), 32'h0);
        repeat (40) @(negedge clk);
        chk("rst no late done", 32'(uo_out), 32'h0);
        rd(6'h3, d); chk("rst no late c", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
